// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the 32x32 register file.
// Optional macro WBARB_ROUND_ROBIN_EN selects round-robin arbitration instead of memory-first priority.
module regfile_wb_arbiter #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] NO_WRITE = ADDR_W'(31)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_pos,
  input  logic [DATA_W-1:0] alu_value,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_pos,
  input  logic [DATA_W-1:0] mem_value,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_pos,
  input  logic [ADDR_W-1:0] chk_pos1,
  input  logic [ADDR_W-1:0] chk_pos2,
  output logic              busy1,
  output logic              busy2,
  output logic [31:0]       busy_vec,
  output logic [ADDR_W-1:0] rf_pos,
  output logic [DATA_W-1:0] rf_writevalue
);

  // Handshake: each source holds valid/pos/value stable until it sees ready;
  // a transfer happens in any cycle where valid && ready, at most one per cycle.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [ADDR_W-1:0] REG_TOP  = ADDR_W'(31);

  logic grant_alu;
  logic grant_mem;

`ifdef WBARB_ROUND_ROBIN_EN
  // Reset value 0 means "ALU was last", so memory wins the first contest.
  logic last_mem_q;
  logic last_mem_d;

  always_comb begin
    grant_alu  = 1'b0;
    grant_mem  = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        grant_mem = !last_mem_q;
        grant_alu = last_mem_q;
      end else begin
        grant_mem = mem_valid;
        grant_alu = alu_valid;
      end
    end
    last_mem_d = last_mem_q;
    if (grant_mem) begin
      last_mem_d = 1'b1;
    end else if (grant_alu) begin
      last_mem_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_mem_q <= 1'b0;
    end else begin
      last_mem_q <= last_mem_d;
    end
  end
`else
  always_comb begin
    grant_mem = !reset && mem_valid;
    grant_alu = !reset && alu_valid && !mem_valid;
  end
`endif

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  logic [ADDR_W-1:0] rf_pos_q;
  logic [ADDR_W-1:0] rf_pos_d;
  logic [DATA_W-1:0] rf_writevalue_q;
  logic [DATA_W-1:0] rf_writevalue_d;
  logic [31:0]       busy_q;
  logic [31:0]       busy_d;
  logic [ADDR_W-1:0] xfer_pos;
  logic [DATA_W-1:0] xfer_value;

  always_comb begin
    xfer_pos        = grant_mem ? mem_pos : alu_pos;
    xfer_value      = grant_mem ? mem_value : alu_value;
    rf_pos_d        = NO_WRITE;
    rf_writevalue_d = rf_writevalue_q;
    if (grant_alu || grant_mem) begin
      rf_writevalue_d = xfer_value;
      // Writes to r0 and r31 are swallowed: consumed but never committed.
      if (xfer_pos != REG_ZERO && xfer_pos != REG_TOP) begin
        rf_pos_d = xfer_pos;
      end
    end
  end

  // Clear first, then set, so a same-cycle reservation keeps the bit high.
  always_comb begin
    busy_d = busy_q;
    if (rf_pos_q != NO_WRITE) begin
      busy_d[rf_pos_q] = 1'b0;
    end
    if (rsv_valid && rsv_pos != REG_ZERO && rsv_pos != REG_TOP) begin
      busy_d[rsv_pos] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_pos_q        <= NO_WRITE;
      rf_writevalue_q <= '0;
      busy_q          <= '0;
    end else begin
      rf_pos_q        <= rf_pos_d;
      rf_writevalue_q <= rf_writevalue_d;
      busy_q          <= busy_d;
    end
  end

  assign rf_pos        = rf_pos_q;
  assign rf_writevalue = rf_writevalue_q;
  assign busy_vec      = busy_q;
  assign busy1         = (chk_pos1 != REG_ZERO) && busy_q[chk_pos1];
  assign busy2         = (chk_pos2 != REG_ZERO) && busy_q[chk_pos2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors, a behavioural model checked every
// cycle, and literal expectations for each scenario.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, rsv_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_pos, mem_pos, rsv_pos, chk_pos1, chk_pos2;
  logic [31:0] alu_value, mem_value;
  logic        busy1, busy2;
  logic [31:0] busy_vec;
  logic [4:0]  rf_pos;
  logic [31:0] rf_writevalue;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_pos(alu_pos), .alu_value(alu_value),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pos(mem_pos), .mem_value(mem_value),
    .rsv_valid(rsv_valid), .rsv_pos(rsv_pos),
    .chk_pos1(chk_pos1), .chk_pos2(chk_pos2),
    .busy1(busy1), .busy2(busy2), .busy_vec(busy_vec),
    .rf_pos(rf_pos), .rf_writevalue(rf_writevalue)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          live = 1'b0;
  bit          busy_m [32];
  logic [4:0]  rf_pos_m;
  logic [31:0] wv_m;
`ifdef WBARB_ROUND_ROBIN_EN
  bit          last_was_mem_m;
`endif

  function automatic void model_grants(output bit ga, output bit gm);
    ga = 1'b0;
    gm = 1'b0;
    if (reset) return;
    if (alu_valid && mem_valid) begin
`ifdef WBARB_ROUND_ROBIN_EN
      if (last_was_mem_m) ga = 1'b1;
      else gm = 1'b1;
`else
      gm = 1'b1;
`endif
    end else begin
      ga = alu_valid;
      gm = mem_valid;
    end
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = busy_m[i];
    return v;
  endfunction

  function automatic logic model_busy(input logic [4:0] idx);
    return (idx != 5'd0) && busy_m[idx];
  endfunction

  // Compare on the falling edge, then advance the model to what the next rising edge commits.
  always @(negedge clock) begin
    bit ga, gm;
    model_grants(ga, gm);
    if (live) begin
      check("m_alu_ready", {31'd0, alu_ready}, {31'd0, ga});
      check("m_mem_ready", {31'd0, mem_ready}, {31'd0, gm});
      check("m_rf_pos", {27'd0, rf_pos}, {27'd0, rf_pos_m});
      check("m_rf_writevalue", rf_writevalue, wv_m);
      check("m_busy_vec", busy_vec, model_vec());
      check("m_busy1", {31'd0, busy1}, {31'd0, model_busy(chk_pos1)});
      check("m_busy2", {31'd0, busy2}, {31'd0, model_busy(chk_pos2)});
    end
    if (reset) begin
      rf_pos_m = 5'd31;
      wv_m     = '0;
      for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
`ifdef WBARB_ROUND_ROBIN_EN
      last_was_mem_m = 1'b0;
`endif
      live = 1'b1;
    end else if (live) begin
      if (rf_pos_m != 5'd31) busy_m[rf_pos_m] = 1'b0;
      if (rsv_valid && rsv_pos != 5'd0 && rsv_pos != 5'd31) busy_m[rsv_pos] = 1'b1;
      rf_pos_m = 5'd31;
      if (gm) begin
        wv_m = mem_value;
        if (mem_pos != 5'd0 && mem_pos != 5'd31) rf_pos_m = mem_pos;
      end else if (ga) begin
        wv_m = alu_value;
        if (alu_pos != 5'd0 && alu_pos != 5'd31) rf_pos_m = alu_pos;
      end
`ifdef WBARB_ROUND_ROBIN_EN
      if (gm) last_was_mem_m = 1'b1;
      else if (ga) last_was_mem_m = 1'b0;
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clock);
  endtask

  logic [3:0] mem_pat, alu_pat;
  logic [4:0] ai, mi;

  initial begin
    reset = 1'b1;
    alu_valid = 1'b1; alu_pos = 5'd3; alu_value = 32'h1111_1111;
    mem_valid = 1'b1; mem_pos = 5'd4; mem_value = 32'h2222_2222;
    rsv_valid = 1'b0; rsv_pos = 5'd0; chk_pos1 = 5'd0; chk_pos2 = 5'd0;

    // Reset for two cycles with both requesters valid
    to_neg();
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    step();
    to_neg();
    check("rst_alu_ready2", {31'd0, alu_ready}, 32'd0);
    check("rst_mem_ready2", {31'd0, mem_ready}, 32'd0);
    check("rst_rf_pos", {27'd0, rf_pos}, 32'd31);
    check("rst_busy_vec", busy_vec, 32'd0);
    check("rst_writevalue", rf_writevalue, 32'd0);
    step();
    reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    step();

    // Contest: both valid for 4 cycles, each side advances only when granted
    ai = 5'd1; mi = 5'd11;
    alu_valid = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_pos = ai; alu_value = 32'hA000_0000 + 32'(ai);
      mem_pos = mi; mem_value = 32'hB000_0000 + 32'(mi);
      to_neg();
      mem_pat[i] = mem_ready;
      alu_pat[i] = alu_ready;
      step();
      if (mem_pat[i]) mi = mi + 5'd1;
      if (alu_pat[i]) ai = ai + 5'd1;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
`ifdef WBARB_ROUND_ROBIN_EN
    check("contest_mem_pattern", {28'd0, mem_pat}, 32'h5);
    check("contest_alu_pattern", {28'd0, alu_pat}, 32'hA);
`else
    check("contest_mem_pattern", {28'd0, mem_pat}, 32'hF);
    check("contest_alu_pattern", {28'd0, alu_pat}, 32'h0);
`endif
    step();

    // Single ALU write
    alu_valid = 1'b1; alu_pos = 5'd5; alu_value = 32'hDEADBEEF;
    to_neg();
    check("alu_ready_single", {31'd0, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    to_neg();
    check("alu_rf_pos", {27'd0, rf_pos}, 32'd5);
    check("alu_writevalue", rf_writevalue, 32'hDEADBEEF);
    step();
    to_neg();
    check("alu_rf_pos_after", {27'd0, rf_pos}, 32'd31);
    step();

    // Scoreboard: reserve 7, memory writes 7 three cycles later
    rsv_valid = 1'b1; rsv_pos = 5'd7; chk_pos1 = 5'd7; chk_pos2 = 5'd7;
    step();
    rsv_valid = 1'b0;
    to_neg();
    check("sb_busy1_set", {31'd0, busy1}, 32'd1);
    check("sb_busy2_set", {31'd0, busy2}, 32'd1);
    step();
    step();
    mem_valid = 1'b1; mem_pos = 5'd7; mem_value = 32'h0000_7777;
    to_neg();
    check("sb_mem_ready", {31'd0, mem_ready}, 32'd1);
    step();
    mem_valid = 1'b0;
    to_neg();
    check("sb_rf_pos7", {27'd0, rf_pos}, 32'd7);
    check("sb_busy1_still", {31'd0, busy1}, 32'd1);
    step();
    to_neg();
    check("sb_busy_vec_clear", busy_vec, 32'd0);
    check("sb_busy1_clear", {31'd0, busy1}, 32'd0);

    // Re-reserve 7 while the write to 7 sits in rf_pos: set wins
    step();
    rsv_valid = 1'b1; rsv_pos = 5'd7;
    step();
    rsv_valid = 1'b0;
    mem_valid = 1'b1; mem_pos = 5'd7; mem_value = 32'h0000_7778;
    step();
    mem_valid = 1'b0;
    rsv_valid = 1'b1; rsv_pos = 5'd7;
    to_neg();
    check("sb_sim_rf_pos", {27'd0, rf_pos}, 32'd7);
    step();
    rsv_valid = 1'b0;
    to_neg();
    check("sb_sim_busy_vec", busy_vec, 32'h0000_0080);
    check("sb_sim_busy1", {31'd0, busy1}, 32'd1);
    step();
    to_neg();
    check("sb_sim_busy_vec2", busy_vec, 32'h0000_0080);
    step();

    // Writes to r0 and r31, reservations of r0 and r31
    alu_valid = 1'b1; alu_pos = 5'd0; alu_value = 32'h0000_0F00;
    to_neg();
    check("r0_alu_ready", {31'd0, alu_ready}, 32'd1);
    step();
    alu_pos = 5'd31; alu_value = 32'h0000_0F31;
    to_neg();
    check("r31_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("r0_rf_pos", {27'd0, rf_pos}, 32'd31);
    step();
    alu_valid = 1'b0;
    to_neg();
    check("r31_rf_pos", {27'd0, rf_pos}, 32'd31);
    check("r031_busy_vec", busy_vec, 32'h0000_0080);
    rsv_valid = 1'b1; rsv_pos = 5'd0; chk_pos1 = 5'd0;
    step();
    rsv_pos = 5'd31;
    to_neg();
    check("rsv0_busy1", {31'd0, busy1}, 32'd0);
    check("rsv0_busy_vec", busy_vec, 32'h0000_0080);
    step();
    rsv_valid = 1'b0;
    to_neg();
    check("rsv31_busy_vec", busy_vec, 32'h0000_0080);
    step();

    // Mid-operation reset: transfer to 9 in N, reset in N+1
    alu_valid = 1'b1; alu_pos = 5'd9; alu_value = 32'h0000_0099;
    rsv_valid = 1'b1; rsv_pos = 5'd9; chk_pos2 = 5'd9;
    to_neg();
    check("mid_alu_ready", {31'd0, alu_ready}, 32'd1);
    step();
    reset = 1'b1; rsv_valid = 1'b0; alu_pos = 5'd3;
    to_neg();
    check("mid_rf_pos9", {27'd0, rf_pos}, 32'd9);
    check("mid_ready_in_reset", {31'd0, alu_ready}, 32'd0);
    step();
    reset = 1'b0; alu_valid = 1'b0;
    to_neg();
    check("mid_rf_pos_reset", {27'd0, rf_pos}, 32'd31);
    check("mid_busy_vec_reset", busy_vec, 32'd0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
